// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Three-port (X debug, D data, I fetch) arbiter onto one sync RAM.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                x_req,
    input  logic [ADDR_W-1:0]   x_addr,
    input  logic                x_we,
    input  logic [DATA_W-1:0]   x_wdata,
    input  logic [DATA_W/8-1:0] x_wstrb,
    input  logic                x_lock,
    output logic                x_gnt,
    output logic                x_rvalid,
    output logic [DATA_W-1:0]   x_rdata,

    input  logic                d_req,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_we,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,

    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_X    = 2'd1,
        OWN_D    = 2'd2,
        OWN_I    = 2'd3
    } owner_t;

    logic   r_rr_last;   // 1: D was the last I/D port served
    logic   r_locked;
    owner_t r_rd_owner;

    logic   w_x_gnt;
    logic   w_d_gnt;
    logic   w_i_gnt;

    always_comb begin
        w_x_gnt = 1'b0;
        w_d_gnt = 1'b0;
        w_i_gnt = 1'b0;
        if (rst_n) begin
            if (r_locked) begin
                w_x_gnt = x_req;
            end else if (x_req) begin
                w_x_gnt = 1'b1;
            end else if (i_req && d_req) begin
                w_i_gnt = r_rr_last;
                w_d_gnt = ~r_rr_last;
            end else begin
                w_i_gnt = i_req;
                w_d_gnt = d_req;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (w_x_gnt) begin
            mem_we    = x_we;
            mem_addr  = x_addr;
            mem_wdata = x_wdata;
            mem_wstrb = x_wstrb;
        end else if (w_d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wstrb = d_wstrb;
        end else if (w_i_gnt) begin
            mem_addr  = i_addr;
            mem_wstrb = {STRB_W{1'b0}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last  <= 1'b1;
            r_locked   <= 1'b0;
            r_rd_owner <= OWN_NONE;
        end else begin
            if (w_i_gnt) begin
                r_rr_last <= 1'b0;
            end else if (w_d_gnt) begin
                r_rr_last <= 1'b1;
            end

            // The cycle that drops x_lock is still X-only; release takes effect after it.
            if (r_locked && !x_lock) begin
                r_locked <= 1'b0;
            end else if (w_x_gnt && x_lock) begin
                r_locked <= 1'b1;
            end

            if (w_x_gnt && !x_we) begin
                r_rd_owner <= OWN_X;
            end else if (w_d_gnt && !d_we) begin
                r_rd_owner <= OWN_D;
            end else if (w_i_gnt) begin
                r_rd_owner <= OWN_I;
            end else begin
                r_rd_owner <= OWN_NONE;
            end
        end
    end

    assign x_gnt    = w_x_gnt;
    assign d_gnt    = w_d_gnt;
    assign i_gnt    = w_i_gnt;
    assign mem_en   = w_x_gnt | w_d_gnt | w_i_gnt;

    assign x_rvalid = (r_rd_owner == OWN_X);
    assign d_rvalid = (r_rd_owner == OWN_D);
    assign i_rvalid = (r_rd_owner == OWN_I);

    assign x_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign i_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter with a behavioural port model.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int PN = 0, PX = 1, PD = 2, PI = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        x_req, x_we, x_lock, d_req, d_we, i_req;
    logic [31:0] x_addr, d_addr, i_addr;
    logic [63:0] x_wdata, d_wdata;
    logic [7:0]  x_wstrb, d_wstrb;
    logic        x_gnt, d_gnt, i_gnt, x_rvalid, d_rvalid, i_rvalid;
    logic [63:0] x_rdata, d_rdata, i_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_wstrb;

    mem_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .x_req(x_req), .x_addr(x_addr), .x_we(x_we), .x_wdata(x_wdata),
        .x_wstrb(x_wstrb), .x_lock(x_lock), .x_gnt(x_gnt),
        .x_rvalid(x_rvalid), .x_rdata(x_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] init_word(int k);
        return 64'(k) * 64'h0001_0003_0007_000F + 64'h0123_4567_89AB_CDEF;
    endfunction

    // Synchronous RAM behind the arbiter; reloads its known image while in reset.
    logic [63:0] ram [0:31];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) ram[k] <= init_word(k);
        end else if (mem_en) begin
            if (mem_we) begin
                for (int k = 0; k < 8; k++)
                    if (mem_wstrb[k]) ram[mem_addr[7:3]][8*k +: 8] <= mem_wdata[8*k +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[7:3]];
            end
        end
    end

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } txn_t;

    typedef struct {
        int          due;
        logic [63:0] data;
    } exp_t;

    txn_t xq[$], dq[$], iq[$];
    exp_t xe[$], de[$], ie[$];

    logic [63:0] ref_mem [0:31];
    bit          m_locked;
    int          m_last;
    bit          mon_en = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic txn_t mk(bit we, logic [31:0] addr, logic [63:0] wdata, logic [7:0] wstrb);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb;
        return t;
    endfunction

    function automatic txn_t rand_txn(bit can_write);
        txn_t t;
        t.addr  = 32'($urandom_range(0, 15)) << 3;
        t.we    = can_write && ($urandom_range(0, 1) == 1);
        t.wdata = {$urandom, $urandom};
        t.wstrb = 8'($urandom);
        return t;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 32; k++) ref_mem[k] = init_word(k);
        xq.delete(); dq.delete(); iq.delete();
        xe.delete(); de.delete(); ie.delete();
        m_locked = 1'b0;
        m_last   = PD;
    endtask

    // One clock of traffic: present queue heads, predict the winner, score it.
    // Entered and left at posedge+1.
    task automatic cycle(input bit lock, input bit xen);
        txn_t t;
        exp_t e;
        int   w;
        int   idx;
        logic [105:0] ecmd;
        x_req = xen && (xq.size() > 0);
        t = x_req ? xq[0] : '0;
        x_we = t.we; x_addr = t.addr; x_wdata = t.wdata; x_wstrb = t.wstrb;
        d_req = (dq.size() > 0);
        t = d_req ? dq[0] : '0;
        d_we = t.we; d_addr = t.addr; d_wdata = t.wdata; d_wstrb = t.wstrb;
        i_req = (iq.size() > 0);
        i_addr = i_req ? iq[0].addr : '0;
        x_lock = lock;
        @(negedge clk);
        // X owns the memory when holding it or asking; otherwise the I/D port
        // served longer ago goes first.
        if (m_locked || x_req)  w = x_req ? PX : PN;
        else if (d_req && i_req) w = (m_last == PI) ? PD : PI;
        else if (d_req)          w = PD;
        else if (i_req)          w = PI;
        else                     w = PN;
        check("gnt", {x_gnt, d_gnt, i_gnt}, {w == PX, w == PD, w == PI});
        ecmd = '0;
        if (w != PN) begin
            t = (w == PX) ? xq.pop_front() : (w == PD) ? dq.pop_front() : iq.pop_front();
            if (w == PI) t = mk(1'b0, t.addr, 64'h0, 8'h0);
            ecmd = {1'b1, t.we, t.addr, t.wdata, t.wstrb};
            idx = int'(t.addr[7:3]);
            if (t.we) begin
                for (int k = 0; k < 8; k++)
                    if (t.wstrb[k]) ref_mem[idx][8*k +: 8] = t.wdata[8*k +: 8];
            end else begin
                e.due = cyc + 1;
                e.data = ref_mem[idx];
                if (w == PX) xe.push_back(e);
                else if (w == PD) de.push_back(e);
                else ie.push_back(e);
            end
            if (w != PX) m_last = w;
        end
        check("mem_cmd", {mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb}, ecmd);
        if (m_locked && !lock) m_locked = 1'b0;
        else if (w == PX && lock) m_locked = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((xq.size() + dq.size() + iq.size()) > 0 && n < bound) begin
            cycle(1'b0, 1'b1);
            n++;
        end
        check("drain_timeout", n < bound, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
    endtask

    // Pull reset one cycle after a read grant of 'port'; the pending return must vanish.
    task automatic mid_reset(input int port);
        check("pre_rst_rvalid", {x_rvalid, d_rvalid, i_rvalid},
              {port == PX, port == PD, port == PI});
        mon_en = 1'b0;
        rst_n  = 1'b0;
        x_req = 1'b1; d_req = 1'b1; i_req = 1'b1; x_we = 1'b0; d_we = 1'b0; x_lock = 1'b1;
        #1;
        check("rst_rvalid", {x_rvalid, d_rvalid, i_rvalid}, 3'b000);
        check("rst_mem_en", mem_en, 1'b0);
        @(negedge clk);
        check("rst_gnt", {x_gnt, d_gnt, i_gnt, mem_en}, 4'b0000);
        @(posedge clk);
        #1;
        reset_model();
        x_req = 1'b0; d_req = 1'b0; i_req = 1'b0; x_lock = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: each rvalid must match the head of its port's expectation queue.
    always @(negedge clk) begin
        bit ev;
        if (mon_en) begin
            ev = (xe.size() > 0) && (xe[0].due == cyc);
            check("x_rvalid", x_rvalid, ev);
            if (ev) check("x_rdata", x_rdata, xe[0].data);
            if (xe.size() > 0 && xe[0].due <= cyc) void'(xe.pop_front());
            ev = (de.size() > 0) && (de[0].due == cyc);
            check("d_rvalid", d_rvalid, ev);
            if (ev) check("d_rdata", d_rdata, de[0].data);
            if (de.size() > 0 && de[0].due <= cyc) void'(de.pop_front());
            ev = (ie.size() > 0) && (ie[0].due == cyc);
            check("i_rvalid", i_rvalid, ev);
            if (ev) check("i_rdata", i_rdata, ie[0].data);
            if (ie.size() > 0 && ie[0].due <= cyc) void'(ie.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] prior;
        rst_n = 1'b0;
        x_req = 1'b1; d_req = 1'b1; i_req = 1'b1; x_lock = 1'b0;
        x_we = 1'b0; d_we = 1'b0;
        x_addr = '0; d_addr = '0; i_addr = '0;
        x_wdata = '0; d_wdata = '0; x_wstrb = '0; d_wstrb = '0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_gnt", {x_gnt, d_gnt, i_gnt, mem_en}, 4'b0000);
        check("reset_rvalid", {x_rvalid, d_rvalid, i_rvalid}, 3'b000);
        @(posedge clk);
        #1;
        x_req = 1'b0; d_req = 1'b0; i_req = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // I and D contend from reset: I first, then strict alternation.
        for (int k = 0; k < 4; k++) begin
            iq.push_back(mk(1'b0, 32'(k * 8), 64'h0, 8'h0));
            dq.push_back(mk(1'b0, 32'h8, 64'h0, 8'h0));
        end
        drain(20);

        // X byte write to lane 0, then read back.
        prior = ref_mem[0];
        xq.push_back(mk(1'b1, 32'h0, 64'h08, 8'h01));
        xq.push_back(mk(1'b0, 32'h0, 64'h0, 8'h0));
        drain(10);
        check("byte_merge", ref_mem[0], {prior[63:8], 8'h08});

        // Locked X burst with a one-cycle request gap while I and D wait.
        for (int k = 0; k < 3; k++) begin
            xq.push_back(mk(1'b0, 32'(k * 8), 64'h0, 8'h0));
            iq.push_back(mk(1'b0, 32'(k * 8 + 32), 64'h0, 8'h0));
            dq.push_back(mk(1'b0, 32'(k * 8 + 64), 64'h0, 8'h0));
        end
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        drain(20);

        // All three request together, unlocked.
        xq.push_back(mk(1'b0, 32'h18, 64'h0, 8'h0));
        dq.push_back(mk(1'b0, 32'h20, 64'h0, 8'h0));
        iq.push_back(mk(1'b0, 32'h28, 64'h0, 8'h0));
        drain(10);

        // Program load over X, then core fetches and stores to 0x10, X reads back.
        xq.push_back(mk(1'b1, 32'h00, 64'h0010_0093_0000_0013, 8'hFF));
        xq.push_back(mk(1'b1, 32'h08, 64'h0020_8113_0010_0093, 8'hFF));
        xq.push_back(mk(1'b1, 32'h10, 64'h0020_3823_0020_8113, 8'hFF));
        xq.push_back(mk(1'b1, 32'h18, 64'h0000_006F_0020_3823, 8'hFF));
        drain(10);
        for (int k = 0; k < 4; k++) iq.push_back(mk(1'b0, 32'(k * 8), 64'h0, 8'h0));
        dq.push_back(mk(1'b1, 32'h10, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF));
        drain(20);
        xq.push_back(mk(1'b0, 32'h10, 64'h0, 8'h0));
        drain(10);
        check("sd_readback", ref_mem[2], 64'hDEAD_BEEF_CAFE_F00D);

        // Randomised mixed traffic with occasional X locking.
        for (int n = 0; n < 400; n++) begin
            if (xq.size() == 0 && $urandom_range(0, 3) == 0) xq.push_back(rand_txn(1'b1));
            if (dq.size() == 0 && $urandom_range(0, 1) == 0) dq.push_back(rand_txn(1'b1));
            if (iq.size() == 0 && $urandom_range(0, 1) == 0) iq.push_back(rand_txn(1'b0));
            cycle($urandom_range(0, 7) == 0, 1'b1);
        end
        drain(50);

        // Reset one cycle after a D read grant.
        dq.push_back(mk(1'b0, 32'h8, 64'h0, 8'h0));
        cycle(1'b0, 1'b1);
        mid_reset(PD);
        iq.push_back(mk(1'b0, 32'h0, 64'h0, 8'h0));
        dq.push_back(mk(1'b0, 32'h8, 64'h0, 8'h0));
        drain(10);

        // Reset one cycle after a locked X read: lock must not survive reset.
        xq.push_back(mk(1'b0, 32'h10, 64'h0, 8'h0));
        cycle(1'b1, 1'b1);
        mid_reset(PX);
        iq.push_back(mk(1'b0, 32'h0, 64'h0, 8'h0));
        dq.push_back(mk(1'b0, 32'h8, 64'h0, 8'h0));
        drain(10);

        check("pending_returns", xe.size() + de.size() + ie.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
